spi_banked_pollable_memory: RTL
===============================

// Module: spi_banked_pollable_memory
// PURPOSE
//  Command-decoding memory that sits behind SPI_slave_command8_address16_data32.
//  - Turns each completed SPI transaction (command8/address16/data32) into an operation on
//    NUM_BANKS banks of block RAM: write, read, auto-increment read, bank clear or status.
//  - Results are loaded into data_to_master, which the slave shifts out on the next transaction.
//  - Instantiated once per board design; feeds leds/debug taps and a pollable status word.
// PARAMETERS
//  ADDR_WIDTH   8   word-address bits per bank (depth per bank = 2**ADDR_WIDTH)
//  BANK_WIDTH   1   bank-select bits (NUM_BANKS = 2**BANK_WIDTH); ADDR_WIDTH+BANK_WIDTH <= 16
//  DATA_WIDTH   32  memory word width; data32 is truncated/zero-extended to this width
// PORTS
//  clock              in   1           system clock (clock16 in top)
//  reset              in   1           synchronous, active-high
//  transaction_valid  in   1           one-clock pulse in clock domain; fields stable while high
//  command8           in   8           opcode
//  address16          in   16          {unused, bank[BANK_WIDTH], word[ADDR_WIDTH]}
//  data32             in   32          write data
//  data_to_master     out  DATA_WIDTH  word returned on next SPI transaction
//  busy               out  1           high during READ_WAIT or CLEAR
//  error              out  1           sticky; set on any rejected transaction
// BEHAVIOUR
//  Reset values: data_to_master=0, busy=0, error=0, error_count=0, transaction_count=0,
//  read_pointer=0, state=IDLE. Memory contents are not touched by reset.
//  Reset mid-operation: returns to IDLE in 1 clock; a partial CLEAR stays partial.
//  Address is in range iff address16[15:ADDR_WIDTH+BANK_WIDTH]==0.
//  Opcodes, accepted only in IDLE; every accepted one increments transaction_count (16 bit, wraps):
//   0x01 WRITE  in range: mem[bank][word]<=data32 at T+1; else dropped, error.
//   0x02 READ   in range: -> READ_WAIT; data_to_master=mem[bank][word] at T+2.
//               out of range: data_to_master<=0 at T+1, error.
//   0x03 READ_NEXT  reads mem[bank][read_pointer] with READ timing; read_pointer++ afterwards,
//               wrapping 2**ADDR_WIDTH-1 -> 0. Word field of address16 is ignored.
//               Bank comes from address16; the bank field is checked like READ.
//   0x04 CLEAR_BANK  -> CLEAR; writes 0 to word 0..2**ADDR_WIDTH-1 of bank, one per clock.
//               Then returns to IDLE (busy for exactly 2**ADDR_WIDTH clocks).
//               Also sets read_pointer=0.
//   0x05 STATUS  data_to_master <= {error_count[15:0], transaction_count[15:0]} at T+1.
//               Value is zero-extended or truncated to DATA_WIDTH; transaction_count includes
//               this STATUS. In the same clock error_count<=0 and error<=0.
//   0x06 SET_POINTER  read_pointer <= word field; bank is ignored.
//   other        dropped, error, transaction_count not incremented.
//  Error handling (T = clock in which transaction_valid is sampled high):
//   - Any error sets error=1 and increments error_count (16 bit, saturates at 0xFFFF).
//   - transaction_valid while busy: dropped, error.
//     Not counted in transaction_count; the in-progress operation is unaffected.
//  FSM: IDLE -(READ/READ_NEXT in range)-> READ_WAIT -(1 clk)-> IDLE;
//       IDLE -(CLEAR_BANK in range)-> CLEAR -(last word)-> IDLE.
//       CLEAR_BANK out of range: error, stay IDLE.
//  Memory: one synchronous-read port and one write port per bank, both on clock.
//   - Reads are registered.
//   - Write and read of the same word in the same clock return the old data.
//  data_to_master holds its value until the next READ/READ_NEXT/STATUS or reset.
// TESTING
//  1 WRITE 0x01/0x0001/0x01234567, then READ 0x02/0x0001 -> data_to_master=0x01234567 at T+2.
//  2 WRITE bank1 addr 0x0101=0x89abcdef, READ 0x0001 -> still 0x01234567 (no bank alias).
//  3 SET_POINTER 0x00FF, READ_NEXT x2 -> mem[0][255], then mem[0][0]; read_pointer=1.
//  4 CLEAR_BANK 0x0000 -> busy 256 clks; WRITE pulsed mid-clear -> dropped, error=1.
//    Afterwards READ 0x0001 -> 0; READ 0x0101 -> 0x89abcdef.
//  5 Opcode 0x7F and READ 0x8000 -> error_count=2; STATUS -> {16'd2, count}; then STATUS -> error_count 0.
//  6 Reset asserted during CLEAR -> busy=0 next clk, data_to_master=0, counters=0.

Source files
------------

// File: rtl/spi_banked_pollable_memory.sv
// Command-decoding banked memory behind an SPI command8/address16/data32 slave.
// Latency: WRITE/STATUS/SET_POINTER take effect the clock after the transaction; READ/READ_NEXT data is ready two clocks after it.
// Backpressure: none; transactions arriving while busy (READ_WAIT or CLEAR) are dropped and flagged as errors.
module spi_banked_pollable_memory #(
   parameter int ADDR_WIDTH = 8,
   parameter int BANK_WIDTH = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  transaction_valid,
   input  logic [7:0]            command8,
   input  logic [15:0]           address16,
   input  logic [31:0]           data32,
   output logic [DATA_WIDTH-1:0] data_to_master,
   output logic                  busy,
   output logic                  error
);

   localparam int NUM_BANKS = 2 ** BANK_WIDTH;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int AB        = ADDR_WIDTH + BANK_WIDTH;
   // Address bits above the bank field must be zero for an address to be in range.
   localparam logic [15:0] HI_MASK = 16'hFFFF << AB;

   localparam logic [7:0] OP_WRITE       = 8'h01;
   localparam logic [7:0] OP_READ        = 8'h02;
   localparam logic [7:0] OP_READ_NEXT   = 8'h03;
   localparam logic [7:0] OP_CLEAR_BANK  = 8'h04;
   localparam logic [7:0] OP_STATUS      = 8'h05;
   localparam logic [7:0] OP_SET_POINTER = 8'h06;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      CLEAR     = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [15:0]             transaction_count;
   logic [15:0]             error_count;
   logic [ADDR_WIDTH-1:0]   read_pointer;
   logic [ADDR_WIDTH-1:0]   clear_index;
   logic [BANK_WIDTH-1:0]   clear_bank;
   logic [BANK_WIDTH-1:0]   read_bank;

   // Decoded address fields.
   logic                    in_range;
   logic [BANK_WIDTH-1:0]   bank_field;
   logic [ADDR_WIDTH-1:0]   word_field;

   // Decoder outputs.
   logic                    cmd_error;
   logic                    count_transaction;
   logic                    do_write;
   logic                    do_read;
   logic [ADDR_WIDTH-1:0]   read_word;
   logic                    pointer_set;
   logic                    pointer_inc;
   logic                    pointer_clear;
   logic                    clear_start;
   logic                    clear_write;
   logic                    do_status;
   logic                    zero_result;

   // Shared write port signals, steered to one bank.
   logic                    write_enable;
   logic [BANK_WIDTH-1:0]   write_bank;
   logic [ADDR_WIDTH-1:0]   write_word;
   logic [DATA_WIDTH-1:0]   write_data;

   logic [DATA_WIDTH-1:0]   read_data [NUM_BANKS];

   assign in_range   = (address16 & HI_MASK) == 16'h0000;
   assign bank_field = address16[AB-1:ADDR_WIDTH];
   assign word_field = address16[ADDR_WIDTH-1:0];
   assign busy       = (state != IDLE);

   // Next-state and command decode; opcodes are only honoured in IDLE.
   always_comb begin
      state_nxt         = state;
      cmd_error         = 1'b0;
      count_transaction = 1'b0;
      do_write          = 1'b0;
      do_read           = 1'b0;
      read_word         = word_field;
      pointer_set       = 1'b0;
      pointer_inc       = 1'b0;
      pointer_clear     = 1'b0;
      clear_start       = 1'b0;
      clear_write       = 1'b0;
      do_status         = 1'b0;
      zero_result       = 1'b0;
      case (state)
         IDLE: begin
            if (transaction_valid) begin
               case (command8)
                  OP_WRITE: begin
                     count_transaction = 1'b1;
                     if (in_range) do_write  = 1'b1;
                     else          cmd_error = 1'b1;
                  end
                  OP_READ, OP_READ_NEXT: begin
                     count_transaction = 1'b1;
                     if (command8 == OP_READ_NEXT) read_word = read_pointer;
                     if (in_range) begin
                        do_read     = 1'b1;
                        pointer_inc = (command8 == OP_READ_NEXT);
                        state_nxt   = READ_WAIT;
                     end else begin
                        cmd_error   = 1'b1;
                        zero_result = 1'b1;
                     end
                  end
                  OP_CLEAR_BANK: begin
                     count_transaction = 1'b1;
                     if (in_range) begin
                        clear_start   = 1'b1;
                        pointer_clear = 1'b1;
                        state_nxt     = CLEAR;
                     end else begin
                        cmd_error = 1'b1;
                     end
                  end
                  OP_STATUS: begin
                     count_transaction = 1'b1;
                     do_status         = 1'b1;
                  end
                  OP_SET_POINTER: begin
                     count_transaction = 1'b1;
                     pointer_set       = 1'b1;
                  end
                  default: cmd_error = 1'b1;
               endcase
            end
         end
         READ_WAIT: begin
            cmd_error = transaction_valid;
            state_nxt = IDLE;
         end
         CLEAR: begin
            cmd_error   = transaction_valid;
            clear_write = 1'b1;
            if (clear_index == ADDR_WIDTH'(DEPTH - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write port steering: the clear sweep owns the port while in CLEAR.
   always_comb begin
      write_enable = (do_write | clear_write) & ~reset;
      write_bank   = clear_write ? clear_bank  : bank_field;
      write_word   = clear_write ? clear_index : word_field;
      write_data   = clear_write ? '0 : DATA_WIDTH'(data32);
   end

   // Control state, counters, pointer and result register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         transaction_count <= 16'h0000;
         error_count       <= 16'h0000;
         error             <= 1'b0;
         read_pointer      <= '0;
         clear_index       <= '0;
         clear_bank        <= '0;
         read_bank         <= '0;
         data_to_master    <= '0;
      end else begin
         state <= state_nxt;
         if (count_transaction) transaction_count <= transaction_count + 16'd1;

         if (do_status) begin
            data_to_master <= DATA_WIDTH'({error_count, transaction_count + 16'd1});
            error_count    <= 16'h0000;
            error          <= 1'b0;
         end else if (cmd_error) begin
            error <= 1'b1;
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
         end

         if (zero_result)              data_to_master <= '0;
         else if (state == READ_WAIT)  data_to_master <= read_data[read_bank];

         if (pointer_clear)     read_pointer <= '0;
         else if (pointer_set)  read_pointer <= word_field;
         else if (pointer_inc)  read_pointer <= read_pointer + 1'b1;

         if (do_read) read_bank <= bank_field;

         if (clear_start) begin
            clear_bank  <= bank_field;
            clear_index <= '0;
         end else if (clear_write) begin
            clear_index <= clear_index + 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      // One write port and one registered read port; same-word read sees old data.
      always_ff @(posedge clock) begin
         if (write_enable && write_bank == BANK_WIDTH'(b)) mem[write_word] <= write_data;
         if (do_read && bank_field == BANK_WIDTH'(b)) read_data[b] <= mem[read_word];
      end
   end

endmodule
